// File: rtl/fir_event_detector_if.sv
// Custom-instruction bus between the Nios II CPU and fir_event_detector.
// The CPU side is the master; the event detector is the slave.
interface fir_event_detector_if;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en, start, n, dataa, datab,
    input  result, done
  );

  modport slave (
    input  clk_en, start, n, dataa, datab,
    output result, done
  );
endinterface

// File: rtl/fir_event_detector.sv
// Gesture event detector custom instruction: signed hysteresis threshold with
// debounce and hold-off, advanced once per PUSH command, with a saturating event counter.
module fir_event_detector #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLDOFF  = 16
) (
  input  logic clk,
  input  logic reset,
  fir_event_detector_if.slave bus
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_t;

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_CONFIG = 2'd1;
  localparam logic [1:0] OP_STATUS = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  localparam logic [3:0] DEB_LIM  = 4'(DEBOUNCE);
  localparam logic [7:0] HOLD_LIM = 8'(HOLDOFF);

  state_t      state_r, state_s;
  logic [31:0] thr_hi_r, thr_hi_s;
  logic [31:0] thr_lo_r, thr_lo_s;
  logic        configured_r, configured_s;
  logic [3:0]  deb_cnt_r, deb_cnt_s;
  logic [7:0]  hold_cnt_r, hold_cnt_s;
  logic [7:0]  event_cnt_r, event_cnt_s;
  logic        fired_r, fired_s;
  logic [31:0] result_r, result_s;
  logic        done_r, done_s;

  logic        accept_s;
  logic        above_s;
  logic        below_s;
  logic        cfg_bad_s;
  logic [3:0]  deb_inc_s;
  logic [7:0]  hold_inc_s;
  logic [7:0]  event_sat_s;

  function automatic logic [31:0] status_word(input logic [1:0] st, input logic fired,
                                              input logic [7:0] cnt);
    status_word = {21'd0, fired, st, cnt};
  endfunction

  assign accept_s    = bus.start & bus.clk_en;
  assign above_s     = $signed(bus.dataa) > $signed(thr_hi_r);
  assign below_s     = $signed(bus.dataa) < $signed(thr_lo_r);
  assign cfg_bad_s   = $signed(bus.datab) > $signed(bus.dataa);
  assign deb_inc_s   = deb_cnt_r + 4'd1;
  assign hold_inc_s  = hold_cnt_r + 8'd1;
  assign event_sat_s = (event_cnt_r == 8'hFF) ? 8'hFF : (event_cnt_r + 8'd1);

  // Command decode and once-per-push detector FSM next-state logic.
  always_comb begin
    state_s      = state_r;
    thr_hi_s     = thr_hi_r;
    thr_lo_s     = thr_lo_r;
    configured_s = configured_r;
    deb_cnt_s    = deb_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    event_cnt_s  = event_cnt_r;
    fired_s      = fired_r;
    result_s     = result_r;
    done_s       = accept_s;

    if (accept_s) begin
      case (bus.n)
        OP_PUSH: begin
          fired_s = 1'b0;
          case (state_r)
            ST_ARMED: begin
              if (above_s) begin
                if (deb_inc_s == DEB_LIM) begin
                  state_s     = ST_ACTIVE;
                  deb_cnt_s   = 4'd0;
                  fired_s     = 1'b1;
                  event_cnt_s = event_sat_s;
                end else begin
                  deb_cnt_s = deb_inc_s;
                end
              end else begin
                deb_cnt_s = 4'd0;
              end
            end
            ST_ACTIVE: begin
              if (below_s) begin
                state_s    = ST_HOLDOFF;
                hold_cnt_s = 8'd0;
              end else begin
                state_s = ST_ACTIVE;
              end
            end
            ST_HOLDOFF: begin
              if (hold_inc_s == HOLD_LIM) begin
                state_s    = ST_ARMED;
                deb_cnt_s  = 4'd0;
                hold_cnt_s = hold_inc_s;
              end else begin
                hold_cnt_s = hold_inc_s;
              end
            end
            default: begin
              state_s = state_r;
            end
          endcase
          result_s = status_word(state_s, fired_s, event_cnt_s);
        end
        OP_CONFIG: begin
          if (cfg_bad_s) begin
            result_s = 32'hFFFF_FFFF;
          end else begin
            thr_hi_s     = bus.dataa;
            thr_lo_s     = bus.datab;
            configured_s = 1'b1;
            state_s      = ST_ARMED;
            deb_cnt_s    = 4'd0;
            hold_cnt_s   = 8'd0;
            fired_s      = 1'b0;
            result_s     = 32'd0;
          end
        end
        OP_STATUS: begin
          fired_s  = 1'b0;
          result_s = status_word(state_r, 1'b0, event_cnt_r);
        end
        OP_CLEAR: begin
          result_s    = {24'd0, event_cnt_r};
          event_cnt_s = 8'd0;
          deb_cnt_s   = 4'd0;
          hold_cnt_s  = 8'd0;
          fired_s     = 1'b0;
          state_s     = configured_r ? ST_ARMED : ST_DISARMED;
        end
        default: begin
          result_s = result_r;
        end
      endcase
    end else begin
      result_s = result_r;
    end
  end

  // State, threshold and counter registers; done is a one-cycle pulse per accepted command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_DISARMED;
      thr_hi_r     <= 32'd0;
      thr_lo_r     <= 32'd0;
      configured_r <= 1'b0;
      deb_cnt_r    <= 4'd0;
      hold_cnt_r   <= 8'd0;
      event_cnt_r  <= 8'd0;
      fired_r      <= 1'b0;
      result_r     <= 32'd0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      thr_hi_r     <= thr_hi_s;
      thr_lo_r     <= thr_lo_s;
      configured_r <= configured_s;
      deb_cnt_r    <= deb_cnt_s;
      hold_cnt_r   <= hold_cnt_s;
      event_cnt_r  <= event_cnt_s;
      fired_r      <= fired_s;
      result_r     <= result_s;
      done_r       <= done_s;
    end
  end

  assign bus.result = result_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_fir_event_detector.sv
// Self-checking bench for fir_event_detector: directed plan plus randomized
// commands, checked against a procedural reference model of the detector rules.
module tb_fir_event_detector;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_event_detector_if bus0 ();
  fir_event_detector_if bus1 ();

  fir_event_detector dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fir_event_detector #(.DEBOUNCE(1), .HOLDOFF(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Reference model: 0=DISARMED 1=ARMED 2=ACTIVE 3=HOLDOFF
  int m_state[2], m_hi[2], m_lo[2], m_cfg[2], m_deb[2], m_hold[2], m_cnt[2];
  int p_deb[2]  = '{4, 1};
  int p_hold[2] = '{16, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_cfg[i] = 0;
      m_deb[i] = 0; m_hold[i] = 0; m_cnt[i] = 0;
    end
  endtask

  function automatic logic [31:0] status(input int i, input int f);
    return 32'(m_cnt[i] + m_state[i] * 256 + f * 1024);
  endfunction

  task automatic model_cmd(input int i, input int op, input int a, input int b,
                           output logic [31:0] e);
    int fired;
    fired = 0;
    case (op)
      0: begin
        if (m_state[i] == 1) begin
          if (a > m_hi[i]) m_deb[i]++; else m_deb[i] = 0;
          if (m_deb[i] == p_deb[i]) begin
            m_state[i] = 2; m_deb[i] = 0; fired = 1;
            if (m_cnt[i] < 255) m_cnt[i]++;
          end
        end else if (m_state[i] == 2) begin
          if (a < m_lo[i]) begin m_state[i] = 3; m_hold[i] = 0; end
        end else if (m_state[i] == 3) begin
          m_hold[i]++;
          if (m_hold[i] == p_hold[i]) begin m_state[i] = 1; m_deb[i] = 0; end
        end
        e = status(i, fired);
      end
      1: begin
        if (b > a) e = 32'hFFFF_FFFF;
        else begin
          m_hi[i] = a; m_lo[i] = b; m_cfg[i] = 1; m_state[i] = 1;
          m_deb[i] = 0; m_hold[i] = 0; e = 32'd0;
        end
      end
      2: e = status(i, 0);
      default: begin
        e = 32'(m_cnt[i]);
        m_cnt[i] = 0; m_deb[i] = 0; m_hold[i] = 0;
        m_state[i] = m_cfg[i] ? 1 : 0;
      end
    endcase
  endtask

  task automatic drive(input int i, input logic st, input logic en, input int op,
                       input int a, input int b);
    if (i == 0) begin
      bus0.start = st; bus0.clk_en = en; bus0.n = op[1:0]; bus0.dataa = a; bus0.datab = b;
    end else begin
      bus1.start = st; bus1.clk_en = en; bus1.n = op[1:0]; bus1.dataa = a; bus1.datab = b;
    end
  endtask

  function automatic logic [31:0] get_result(input int i);
    return (i == 0) ? bus0.result : bus1.result;
  endfunction

  function automatic logic get_done(input int i);
    return (i == 0) ? bus0.done : bus1.done;
  endfunction

  // Issue one command, check done and result one cycle later; returns observed result.
  task automatic run_cmd(input int i, input int op, input int a, input int b,
                         input string tag, output logic [31:0] obs);
    logic [31:0] e;
    @(negedge clk);
    drive(i, 1'b1, 1'b1, op, a, b);
    model_cmd(i, op, a, b, e);
    @(negedge clk);
    drive(i, 1'b0, 1'b1, 0, 0, 0);
    check({tag, " done"}, {31'd0, get_done(i)}, 32'd1);
    obs = get_result(i);
    check(tag, obs, e);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] e;
    int op, a, b, sel;

    reset = 1'b1;
    drive(0, 1'b0, 1'b1, 0, 0, 0);
    drive(1, 1'b0, 1'b1, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: mid-run reset, including one between start and done
    run_cmd(0, 1, 100, 20, "pre cfg", r);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 0, 500, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 0, 0, 0);
    model_reset();
    check("reset done", {31'd0, bus0.done}, 32'd0);
    check("reset result", bus0.result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post reset done", {31'd0, bus0.done}, 32'd0);
    run_cmd(0, 2, 0, 0, "status disarmed", r);
    check("status disarmed const", r, 32'h0000_0000);
    run_cmd(0, 0, 32'h7FFF_FFFF, 0, "push disarmed", r);
    check("push disarmed const", r, 32'h0000_0000);

    // 2: config accept and reject
    run_cmd(0, 1, 100, 20, "cfg ok", r);
    check("cfg ok const", r, 32'd0);
    @(negedge clk);
    check("done one cycle", {31'd0, bus0.done}, 32'd0);
    run_cmd(0, 2, 0, 0, "status armed", r);
    check("status armed const", r, 32'h0000_0100);
    run_cmd(0, 1, 100, 200, "cfg bad", r);
    check("cfg bad const", r, 32'hFFFF_FFFF);
    run_cmd(0, 2, 0, 0, "status after bad", r);

    // 3: debounce with equality reset
    run_cmd(0, 0, 101, 0, "p101a", r);
    run_cmd(0, 0, 101, 0, "p101b", r);
    run_cmd(0, 0, 100, 0, "p100 eq", r);
    for (int k = 0; k < 4; k++) run_cmd(0, 0, 101, 0, "deb push", r);
    check("fire const", r, 32'h0000_0601);
    run_cmd(0, 2, 0, 0, "status active", r);
    check("status active const", r, 32'h0000_0201);

    // 4: low threshold boundary and hold-off
    run_cmd(0, 0, 20, 0, "p20 eq lo", r);
    check("p20 const", r, 32'h0000_0201);
    run_cmd(0, 0, 19, 0, "p19", r);
    check("p19 const", r, 32'h0000_0301);
    for (int k = 0; k < 16; k++) run_cmd(0, 0, 500, 0, "holdoff push", r);
    check("rearm const", r, 32'h0000_0101);
    for (int k = 0; k < 4; k++) run_cmd(0, 0, 500, 0, "second event", r);
    check("second event const", r, 32'h0000_0602);

    // 5: saturation with DEBOUNCE=1, HOLDOFF=1
    run_cmd(1, 1, 100, 20, "sat cfg", r);
    for (int k = 0; k < 300; k++) begin
      run_cmd(1, 0, 500, 0, "sat hi", r);
      run_cmd(1, 0, 0, 0, "sat lo1", r);
      run_cmd(1, 0, 0, 0, "sat lo2", r);
    end
    run_cmd(1, 2, 0, 0, "sat status", r);
    check("sat status const", r, 32'h0000_01FF);
    run_cmd(1, 3, 0, 0, "sat clear", r);
    check("sat clear const", r, 32'h0000_00FF);
    run_cmd(1, 2, 0, 0, "after clear", r);
    check("after clear const", r, 32'h0000_0100);

    // 6: back-to-back starts with clk_en gap, negative thresholds
    run_cmd(0, 1, -10, -50, "neg cfg", r);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 0, -9, 0);
    model_cmd(0, 0, -9, 0, e);
    @(negedge clk);
    check("b2b1 done", {31'd0, bus0.done}, 32'd1);
    check("b2b1 result", bus0.result, e);
    drive(0, 1'b1, 1'b1, 0, -9, 0);
    model_cmd(0, 0, -9, 0, e);
    @(negedge clk);
    check("b2b2 done", {31'd0, bus0.done}, 32'd1);
    check("b2b2 result", bus0.result, e);
    drive(0, 1'b1, 1'b0, 0, -9, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("clk_en low done", {31'd0, bus0.done}, 32'd0);
      check("clk_en low result hold", bus0.result, e);
    end
    drive(0, 1'b1, 1'b1, 0, -9, 0);
    model_cmd(0, 0, -9, 0, e);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 0, 0, 0);
    check("b2b3 done", {31'd0, bus0.done}, 32'd1);
    check("b2b3 result", bus0.result, e);
    @(negedge clk);
    check("b2b3 single done", {31'd0, bus0.done}, 32'd0);
    run_cmd(0, 0, -9, 0, "neg fire", r);
    check("neg fire const", r, 32'h0000_0603);
    run_cmd(0, 0, -50, 0, "neg eq lo", r);
    check("neg eq lo const", r, 32'h0000_0203);
    run_cmd(0, 0, -51, 0, "neg below", r);
    check("neg below const", r, 32'h0000_0303);

    // Randomized commands on the default-parameter instance
    for (int k = 0; k < 600; k++) begin
      sel = int'($urandom_range(0, 99));
      a = int'($urandom_range(0, 240)) - 120;
      b = int'($urandom_range(0, 240)) - 120;
      if (sel < 5) op = 1;
      else if (sel < 9) op = 2;
      else if (sel < 11) op = 3;
      else op = 0;
      if (op == 0 && sel > 96) a = (sel == 97) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if (sel >= 11 && sel < 15) begin
        @(negedge clk);
        drive(0, 1'b1, 1'b0, op, a, b);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 0, 0, 0);
        check("rand gated done", {31'd0, bus0.done}, 32'd0);
      end else begin
        run_cmd(0, op, a, b, "rand", r);
      end
    end
    run_cmd(0, 2, 0, 0, "rand final status", r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
